// File: rtl/nf_run_ctrl_pkg.sv
// Shared types for the nanoFOX run/halt/step sequencer: FSM states, command opcodes and
// halt-cause codes.
package nf_run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BP   = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    OP_HALT   = 2'd0,
    OP_RUN    = 2'd1,
    OP_STEP   = 2'd2,
    OP_RUN_BP = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_HALT  = 2'd1,
    CAUSE_STEP  = 2'd2,
    CAUSE_BP    = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/nf_bp_unit.sv
// Breakpoint register with equality compare; first_flag masks the hit on the first cycle
// after RUN_BP so an instruction already sitting at the breakpoint executes once.
module nf_bp_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bp_we_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              first_set_i,
  input  logic              first_clr_i,
  output logic              bp_hit_o,
  output logic              bp_stop_o
);

  logic [ADDR_W-1:0] bp_reg_q, bp_reg_d;
  logic              first_q, first_d;

  always_comb begin
    bp_reg_d = bp_we_i ? bp_addr_i : bp_reg_q;
    first_d  = first_q;
    if (first_set_i) begin
      first_d = 1'b1;
    end else if (first_clr_i) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bp_reg_q <= '0;
      first_q  <= 1'b0;
    end else begin
      bp_reg_q <= bp_reg_d;
      first_q  <= first_d;
    end
  end

  assign bp_hit_o  = (instr_addr_i == bp_reg_q);
  assign bp_stop_o = bp_hit_o & ~first_q;

endmodule

// File: rtl/nf_cpu_run_ctrl.sv
// Run/halt/step/run-to-breakpoint sequencer producing cpu_en for the single-cycle nanoFOX CPU.
// Optional NF_RUN_CTRL_CYCLE_CNT_EN builds the enabled-cycle counter on cyc_cnt.
module nf_cpu_run_ctrl
  import nf_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic              bp_we,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              cpu_en,
  output logic              halted,
  output logic              step_done,
  output logic [1:0]        halt_cause,
  output logic [31:0]       cyc_cnt
);

  run_state_e        state_q, state_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  halt_cause_e       cause_q, cause_d;
  logic              step_done_q, step_done_d;
  logic              cmd_acc;
  logic              first_set;
  logic              bp_hit;
  logic              bp_stop;

  nf_bp_unit #(
    .ADDR_W (ADDR_W)
  ) u_bp_unit (
    .clk_i        (clk),
    .rst_i        (resetn),
    .bp_we_i      (bp_we),
    .bp_addr_i    (bp_addr_i),
    .instr_addr_i (instr_addr),
    .first_set_i  (first_set),
    .first_clr_i  (state_q == S_BP),
    .bp_hit_o     (bp_hit),
    .bp_stop_o    (bp_stop)
  );

  assign cmd_acc = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= S_HALT;
      step_cnt_q  <= '0;
      cause_q     <= CAUSE_RESET;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      cause_q     <= cause_d;
      step_done_q <= step_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    cause_d     = cause_q;
    step_done_d = 1'b0;
    first_set   = 1'b0;
    unique case (state_q)
      S_HALT: begin
        if (cmd_acc) begin
          unique case (cmd_op_e'(cmd_op))
            OP_HALT: cause_d = CAUSE_HALT;
            OP_RUN:  state_d = S_RUN;
            OP_STEP: begin
              state_d    = S_STEP;
              step_cnt_d = (cmd_cnt == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cmd_cnt;
            end
            OP_RUN_BP: begin
              state_d   = S_BP;
              first_set = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
          cause_d = CAUSE_HALT;
        end
      end
      S_STEP: begin
        // halt_req wins over the last step, suppressing step_done.
        if (halt_req) begin
          state_d = S_HALT;
          cause_d = CAUSE_HALT;
        end else begin
          if (step_cnt_q != '0) begin
            step_cnt_d = step_cnt_q - 1'b1;
          end
          if (step_cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d     = S_HALT;
            cause_d     = CAUSE_STEP;
            step_done_d = 1'b1;
          end
        end
      end
      S_BP: begin
        if (halt_req) begin
          state_d = S_HALT;
          cause_d = CAUSE_HALT;
        end else if (bp_stop) begin
          state_d = S_HALT;
          cause_d = CAUSE_BP;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    cpu_en = 1'b0;
    unique case (state_q)
      S_RUN, S_STEP: cpu_en = ~halt_req;
      S_BP:          cpu_en = ~halt_req & ~bp_stop;
      default:       cpu_en = 1'b0;
    endcase
    // Reset is synchronous, but the CPU must stop in the reset cycle itself.
    cpu_en    = cpu_en & ~resetn;
    cmd_ready = (state_q == S_HALT) & ~halt_req;
    halted    = (state_q == S_HALT);
  end

  assign step_done  = step_done_q;
  assign halt_cause = cause_q;

`ifdef NF_RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (cmd_acc && (cmd_op_e'(cmd_op) != OP_HALT)) begin
      cyc_cnt_d = '0;
    end else if (cpu_en) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`else
  assign cyc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nf_cpu_run_ctrl.sv
// Directed + randomized bench for nf_cpu_run_ctrl; a looping PC (0x00..0x1C) stands in for the CPU.
module tb_nf_cpu_run_ctrl;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              bp_we;
  logic [ADDR_W-1:0] bp_addr_i;
  logic              halt_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              cpu_en;
  logic              halted;
  logic              step_done;
  logic [1:0]        halt_cause;
  logic [31:0]       cyc_cnt;

  int unsigned       errors = 0;
  int unsigned       checks = 0;
  logic [ADDR_W-1:0] pc;

  nf_cpu_run_ctrl #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_cnt    (cmd_cnt),
    .bp_we      (bp_we),
    .bp_addr_i  (bp_addr_i),
    .halt_req   (halt_req),
    .instr_addr (instr_addr),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .step_done  (step_done),
    .halt_cause (halt_cause),
    .cyc_cnt    (cyc_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cyc(input logic [31:0] n);
`ifdef NF_RUN_CTRL_CYCLE_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle, then let the modelled CPU advance its PC if it was enabled.
  task automatic cyc(output logic en, output logic sd, output logic hl);
    @(negedge clk);
    en = cpu_en;
    sd = step_done;
    hl = halted;
    @(posedge clk);
    #1;
    if (en) pc = (pc + 32'd4) & 32'h1f;
    instr_addr = pc;
  endtask

  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    @(negedge clk);
    check("cmd_ready_on_issue", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step_test(input int cnt);
    logic en, sd, hl;
    int   n, sdn, sd_at, last_en, exp;
    n = 0; sdn = 0; sd_at = -1; last_en = -1;
    exp = (cnt == 0) ? 1 : cnt;
    issue(2'd2, CNT_W'(cnt));
    for (int i = 0; i < exp + 6; i++) begin
      cyc(en, sd, hl);
      if (en) begin n++; last_en = i; end
      if (sd) begin sdn++; sd_at = i; end
    end
    check("step_en_count", n, exp);
    check("step_en_contig", last_en, exp - 1);
    check("step_done_pulses", sdn, 1);
    check("step_done_timing", sd_at, last_en + 1);
    check("step_halted", {31'd0, halted}, 32'd1);
    check("step_cause", {30'd0, halt_cause}, 32'd2);
    check("step_cyc_cnt", cyc_cnt, exp_cyc(exp));
  endtask

  // Instructions executed before the stop: distance to bp around the 8-entry loop, 8 if already there.
  task automatic bp_test(input logic [ADDR_W-1:0] start, input logic [ADDR_W-1:0] bp);
    logic en, sd, hl;
    int   n, d, exp;
    n = 0;
    d = int'((bp - start) >> 2) & 7;
    exp = (d == 0) ? 8 : d;
    pc = start;
    instr_addr = pc;
    bp_we = 1'b1;
    bp_addr_i = bp;
    cyc(en, sd, hl);
    bp_we = 1'b0;
    issue(2'd3, '0);
    for (int i = 0; i < 20; i++) begin
      cyc(en, sd, hl);
      if (hl) break;
      if (en) n++;
    end
    check("bp_exec_count", n, exp);
    check("bp_stop_pc", pc, bp);
    check("bp_halted", {31'd0, halted}, 32'd1);
    check("bp_cpu_en_at_bp", {31'd0, cpu_en}, 32'd0);
    check("bp_cause", {30'd0, halt_cause}, 32'd3);
  endtask

  initial begin
    logic en, sd, hl;
    int   n;
    resetn = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0;
    bp_we = 1'b0; bp_addr_i = '0; halt_req = 1'b0;
    pc = '0; instr_addr = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_cause", {30'd0, halt_cause}, 32'd0);
    check("rst_cyc_cnt", cyc_cnt, 32'd0);
    check("rst_step_done", {31'd0, step_done}, 32'd0);
    @(posedge clk); #1;

    step_test(3);
    step_test(0);
    step_test(7);
    for (int k = 0; k < 4; k++) step_test(int'($urandom_range(1, 20)));

    bp_test(32'h0, 32'h10);
    bp_test(32'h10, 32'h10);
    for (int k = 0; k < 4; k++) begin
      bp_test(32'($urandom_range(0, 7)) << 2, 32'($urandom_range(0, 7)) << 2);
    end

    issue(2'd0, '0);
    @(negedge clk);
    check("haltcmd_cause", {30'd0, halt_cause}, 32'd1);
    check("haltcmd_halted", {31'd0, halted}, 32'd1);
    @(posedge clk); #1;

    // RUN, then halt_req after 5 enabled cycles.
    issue(2'd1, '0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(en, sd, hl);
      if (en) n++;
    end
    check("run_en_count", n, 5);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    @(negedge clk);
    check("run_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    halt_req = 1'b1;
    #1;
    check("hreq_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(posedge clk); #1;
    halt_req = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("hreq_halted", {31'd0, halted}, 32'd1);
    check("hreq_cause", {30'd0, halt_cause}, 32'd1);
    check("hreq_cyc_cnt", cyc_cnt, exp_cyc(5));
    @(posedge clk); #1;

    // halt_req coincides with the last STEP cycle.
    issue(2'd2, 16'd4);
    for (int i = 0; i < 3; i++) cyc(en, sd, hl);
    halt_req = 1'b1;
    cyc(en, sd, hl);
    check("laststep_cpu_en", {31'd0, en}, 32'd0);
    halt_req = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(en, sd, hl);
      if (sd) n++;
    end
    check("laststep_no_done", n, 0);
    check("laststep_cause", {30'd0, halt_cause}, 32'd1);
    check("laststep_halted", {31'd0, halted}, 32'd1);

    // Reset during RUN.
    issue(2'd1, '0);
    for (int i = 0; i < 3; i++) cyc(en, sd, hl);
    resetn = 1'b1;
    @(negedge clk);
    check("rstrun_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check("rstrun_halted", {31'd0, halted}, 32'd1);
    check("rstrun_cause", {30'd0, halt_cause}, 32'd0);
    check("rstrun_cyc_cnt", cyc_cnt, 32'd0);
    check("rstrun_cpu_en_after", {31'd0, cpu_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
